// File: rtl/rom_fetch_unit_pkg.sv
// Shared widths, reset defaults and the prefetch entry type for the ROM fetch unit.
package rom_fetch_unit_pkg;

  localparam int unsigned ADDR_WIDTH         = 8;
  localparam int unsigned DATA_WIDTH         = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_ADDR = 8'h00;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2**ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/rom_fetch_unit_if.sv
// ROM read port, jump request and output byte stream of the fetch unit.
interface rom_fetch_unit_if;
  import rom_fetch_unit_pkg::*;

  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    output rom_addr,
    input  rom_data,
    input  jump_en,
    input  jump_addr,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_addr
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output jump_en,
    output jump_addr,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_addr
  );

endinterface

// File: rtl/rom_fetch_unit_chk.sv
// Structural invariants of the prefetch FIFO: no overflow and head flag consistent with occupancy.
module rom_fetch_unit_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push_i,
  input logic             flush_i,
  input logic             head_valid_i,
  input logic [CNT_W-1:0] count_i
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && (count_i == DEPTH_C)));

  a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    count_i <= DEPTH_C);

  a_head_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
    head_valid_i == (count_i != '0));

endmodule

// File: rtl/rom_fetch_unit_fifo.sv
// Prefetch FIFO of fetch entries with a registered head, so a push into an empty
// FIFO is visible at the head in the very next cycle.
module rom_fetch_unit_fifo
  import rom_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  fetch_entry_t     wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             head_valid_o,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_next_s;
  logic [CNT_W-1:0] count_q, count_d;
  logic             head_valid_q, head_valid_d;
  fetch_entry_t     head_q, head_d;
  logic             push_s, pop_s;

  assign push_s    = push_i && !flush_i;
  assign pop_s     = pop_i && head_valid_q && !flush_i;
  assign rd_next_s = rd_ptr_q + PTR_W'(1);

  // Next pointers, occupancy and head; the head is the entry that will be oldest after this edge.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    head_d       = head_q;
    if (flush_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_next_s;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (pop_s) begin
        if (count_q > CNT_W'(1)) begin
          head_d       = mem_q[rd_next_s];
          head_valid_d = 1'b1;
        end else if (push_s) begin
          head_d       = wdata_i;
          head_valid_d = 1'b1;
        end else begin
          head_valid_d = 1'b0;
        end
      end else if (!head_valid_q && push_s) begin
        head_d       = wdata_i;
        head_valid_d = 1'b1;
      end else begin
        head_d       = head_q;
        head_valid_d = head_valid_q;
      end
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  // Entry storage; a flushed FIFO simply rewinds its pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;
  assign count_o      = count_q;

  rom_fetch_unit_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push_i),
    .flush_i      (flush_i),
    .head_valid_i (head_valid_q),
    .count_i      (count_q)
  );

endmodule

// File: rtl/rom_fetch_unit.sv
// Program-ROM read initiator: sequential PC, one-deep read-latency tracker, prefetch FIFO
// and jump redirection with flush of all stale bytes.
module rom_fetch_unit
  import rom_fetch_unit_pkg::*;
#(
  parameter int unsigned           FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input logic              clk,
  input logic              rst_n,
  rom_fetch_unit_if.master bus
);

  localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] tag_q, tag_d;
  logic                  req_q, req_d;
  logic [CNT_W-1:0]      count_s;
  logic [CNT_W-1:0]      committed_s;
  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  head_valid_s;
  fetch_entry_t          head_s;
  fetch_entry_t          wr_entry_s;

  // Slots already spoken for: stored bytes plus the one still in the ROM; a same-cycle pop earns no credit.
  assign committed_s = count_s + {{(CNT_W-1){1'b0}}, req_q};
  assign issue_s     = committed_s < DEPTH_C;

  assign push_s     = req_q && !bus.jump_en;
  assign pop_s      = head_valid_s && bus.out_ready;
  assign wr_entry_s = '{addr: tag_q, data: bus.rom_data};

  // Fetch pointer and latency tracker; a jump discards the in-flight read and suppresses issue.
  always_comb begin
    pc_d  = pc_q;
    tag_d = tag_q;
    req_d = 1'b0;
    if (bus.jump_en) begin
      pc_d  = bus.jump_addr;
      req_d = 1'b0;
    end else if (issue_s) begin
      pc_d  = addr_inc(pc_q);
      tag_d = pc_q;
      req_d = 1'b1;
    end else begin
      pc_d  = pc_q;
      req_d = 1'b0;
    end
  end

  // PC / tag / request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_ADDR;
      tag_q <= '0;
      req_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      tag_q <= tag_d;
      req_q <= req_d;
    end
  end

  rom_fetch_unit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push_s),
    .wdata_i      (wr_entry_s),
    .pop_i        (pop_s),
    .flush_i      (bus.jump_en),
    .head_valid_o (head_valid_s),
    .head_o       (head_s),
    .count_o      (count_s)
  );

  assign bus.rom_addr  = pc_q;
  assign bus.out_valid = head_valid_s;
  assign bus.out_data  = head_s.data;
  assign bus.out_addr  = head_s.addr;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: queue-level stream model checked every cycle, plus literal pins.
module tb_rom_fetch_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  rom_fetch_unit_if bus ();

  rom_fetch_unit #(
    .FIFO_DEPTH (4),
    .RESET_ADDR (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Program ROM: one-cycle registered read, ROM[i] = i ^ A5.
  always @(posedge clk) bus.rom_data <= bus.rom_addr ^ 8'hA5;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: PC, address in flight in the ROM (-1 none), queue of buffered byte addresses.
  int m_pc = 0;
  int m_inflight = -1;
  int m_fifo[$];
  int m_occ;
  bit m_iss;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fifo.delete();
      m_inflight = -1;
      m_pc = 0;
    end else if (bus.jump_en) begin
      m_fifo.delete();
      m_inflight = -1;
      m_pc = int'(bus.jump_addr);
    end else begin
      m_occ = m_fifo.size();
      m_iss = (m_occ + ((m_inflight >= 0) ? 1 : 0)) < 4;
      if (m_occ > 0 && bus.out_ready) void'(m_fifo.pop_front());
      if (m_inflight >= 0) m_fifo.push_back(m_inflight);
      if (m_iss) begin
        m_inflight = m_pc;
        m_pc = (m_pc + 1) % 256;
      end else begin
        m_inflight = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("model_valid", 32'(bus.out_valid), (m_fifo.size() > 0) ? 1 : 0);
      check("model_rom_addr", 32'(bus.rom_addr), m_pc);
      if (m_fifo.size() > 0) begin
        check("model_out_addr", 32'(bus.out_addr), m_fifo[0]);
        check("model_out_data", 32'(bus.out_data), (m_fifo[0] ^ 32'hA5) & 32'hFF);
      end
    end
  end

  task automatic cyc(input logic jen, input logic [7:0] ja, input logic rdy);
    @(negedge clk);
    bus.jump_en   = jen;
    bus.jump_addr = ja;
    bus.out_ready = rdy;
    #1;
  endtask

  // Asynchronous reset pulse inside one clock-high phase; released before the next negedge.
  task automatic reset_seq(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rst_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_rst_rom_addr"}, 32'(bus.rom_addr), 0);
    check({tag, "_rst_out_data"}, 32'(bus.out_data), 0);
    check({tag, "_rst_out_addr"}, 32'(bus.out_addr), 0);
    #1 rst_n = 1'b1;
  endtask

  task automatic expect_byte(input string name, input int a, input int d);
    check({name, "_valid"}, 32'(bus.out_valid), 1);
    check({name, "_addr"}, 32'(bus.out_addr), a);
    check({name, "_data"}, 32'(bus.out_data), d);
  endtask

  task automatic case1(input string tag);
    cyc(1'b0, 8'h00, 1'b1);
    check({tag, "_c0_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_c0_rom_addr"}, 32'(bus.rom_addr), 32'h00);
    cyc(1'b0, 8'h00, 1'b1);
    check({tag, "_c1_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_c1_rom_addr"}, 32'(bus.rom_addr), 32'h01);
    cyc(1'b0, 8'h00, 1'b1);
    expect_byte({tag, "_c2"}, 32'h00, 32'hA5);
    cyc(1'b0, 8'h00, 1'b1);
    expect_byte({tag, "_c3"}, 32'h01, 32'hA4);
    cyc(1'b0, 8'h00, 1'b1);
    expect_byte({tag, "_c4"}, 32'h02, 32'hA7);
  endtask

  logic [7:0] wrap_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0] wrap_d [4] = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};

  initial begin
    bus.jump_en   = 1'b0;
    bus.jump_addr = 8'h00;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    reset_seq("init");
    chk_en = 1'b1;

    // Stream from reset.
    case1("t1");

    // Jump to 40 while streaming.
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h40, 1'b1);
    expect_byte("t3_j", 32'h04, 32'hA1);
    cyc(1'b0, 8'h00, 1'b1);
    check("t3_j1_valid", 32'(bus.out_valid), 0);
    cyc(1'b0, 8'h00, 1'b1);
    check("t3_j2_valid", 32'(bus.out_valid), 0);
    cyc(1'b0, 8'h00, 1'b1);
    expect_byte("t3_j3", 32'h40, 32'hE5);
    cyc(1'b0, 8'h00, 1'b1);
    expect_byte("t3_j4", 32'h41, 32'hE4);

    // Jump to FE: address wraps through FF to 00.
    cyc(1'b1, 8'hFE, 1'b1);
    expect_byte("t4_j", 32'h42, 32'hE7);
    cyc(1'b0, 8'h00, 1'b1);
    check("t4_j1_valid", 32'(bus.out_valid), 0);
    cyc(1'b0, 8'h00, 1'b1);
    check("t4_j2_valid", 32'(bus.out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      expect_byte("t4_wrap", 32'(wrap_a[i]), 32'(wrap_d[i]));
    end

    // Back-to-back jumps, the first together with a pop.
    cyc(1'b1, 8'h10, 1'b1);
    check("t5_pop_valid", 32'(bus.out_valid), 1);
    cyc(1'b1, 8'h20, 1'b1);
    check("t5_j1_valid", 32'(bus.out_valid), 0);
    cyc(1'b0, 8'h00, 1'b1);
    check("t5_j2_valid", 32'(bus.out_valid), 0);
    cyc(1'b0, 8'h00, 1'b1);
    check("t5_j3_valid", 32'(bus.out_valid), 0);
    cyc(1'b0, 8'h00, 1'b1);
    expect_byte("t5_j4", 32'h20, 32'h85);
    cyc(1'b0, 8'h00, 1'b1);
    expect_byte("t5_j5", 32'h21, 32'h84);

    // Back-pressure from reset: FIFO fills, PC stalls at 04, then drains in order.
    reset_seq("t2");
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b0);
    expect_byte("t2_full_head", 32'h00, 32'hA5);
    check("t2_stall_rom_addr", 32'(bus.rom_addr), 32'h04);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      expect_byte("t2_drain", i, i ^ 32'hA5);
    end

    // Mid-cycle reset while streaming, then the reset-release sequence again.
    check("t6_pre_valid", 32'(bus.out_valid), 1);
    reset_seq("t6");
    case1("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
